// File: rtl/bsc_axiu_axis_tid_demux_pkg.sv
// Shared types and constants for the tid-based AXI-Stream demultiplexer.
package bsc_axiu_axis_tid_demux_pkg;

  localparam int DATA_W = 64;
  localparam int DEST_W = 2;

  localparam logic [31:0] DROP_COUNT_MAX = 32'hFFFF_FFFF;

  // Routing FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } demux_state_e;

  // Beat payload without the tid field; tid is prepended because its width is a parameter.
  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [DEST_W-1:0] tdest;
    logic              tlast;
  } beat_payload_t;

  // Total stored beat width: tdata + tdest + tid + tlast.
  function automatic int beat_width(input int id_width);
    return DATA_W + DEST_W + id_width + 1;
  endfunction

endpackage

// File: rtl/bsc_axiu_axis_tid_demux_if.sv
// Merged input stream plus the per-port output streams of the tid demux.
interface bsc_axiu_axis_tid_demux_if #(
  parameter int ID_WIDTH  = 1,
  parameter int NUM_PORTS = 2
);
  import bsc_axiu_axis_tid_demux_pkg::*;

  logic [DATA_W-1:0]           S_AXIS_tdata;
  logic [DEST_W-1:0]           S_AXIS_tdest;
  logic [ID_WIDTH-1:0]         S_AXIS_tid;
  logic                        S_AXIS_tlast;
  logic                        S_AXIS_tvalid;
  logic                        S_AXIS_tready;

  logic [DATA_W*NUM_PORTS-1:0] M_AXIS_tdata;
  logic [DEST_W*NUM_PORTS-1:0] M_AXIS_tdest;
  logic [NUM_PORTS-1:0]        M_AXIS_tlast;
  logic [NUM_PORTS-1:0]        M_AXIS_tvalid;
  logic [NUM_PORTS-1:0]        M_AXIS_tready;

  // The demux itself: sinks the merged stream, sources the per-port streams.
  modport slave (
    input  S_AXIS_tdata, S_AXIS_tdest, S_AXIS_tid, S_AXIS_tlast, S_AXIS_tvalid,
    output S_AXIS_tready,
    output M_AXIS_tdata, M_AXIS_tdest, M_AXIS_tlast, M_AXIS_tvalid,
    input  M_AXIS_tready
  );

  // The environment around the demux: drives the merged stream, sinks the outputs.
  modport master (
    output S_AXIS_tdata, S_AXIS_tdest, S_AXIS_tid, S_AXIS_tlast, S_AXIS_tvalid,
    input  S_AXIS_tready,
    input  M_AXIS_tdata, M_AXIS_tdest, M_AXIS_tlast, M_AXIS_tvalid,
    output M_AXIS_tready
  );

endinterface

// File: rtl/bsc_axis_skid_buffer.sv
// Two-entry FIFO with a registered input ready, giving full throughput without
// a combinational path from the consumer back to the producer.
module bsc_axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_pop
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [1:0]       count_next;
  logic             push;
  logic             pop;

  assign push      = in_valid && in_ready;
  assign pop       = out_pop && out_valid;
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];

  // Occupancy after this cycle's push and pop; ready is derived from it.
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 2'd1;
    end else if (pop && !push) begin
      count_next = count - 2'd1;
    end
  end

  // Pointers, occupancy and the registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      in_ready <= 1'b0;
    end else begin
      count    <= count_next;
      in_ready <= (count_next != 2'd2);
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: rtl/bsc_axiu_axis_tid_demux.sv
// Routes whole packets from the merged stream to a per-accelerator port chosen
// by the tid of the first beat; packets with an unknown tid are dropped and counted.
module bsc_axiu_axis_tid_demux
  import bsc_axiu_axis_tid_demux_pkg::*;
#(
  parameter int ID_WIDTH  = 1,
  parameter int NUM_PORTS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  bsc_axiu_axis_tid_demux_if.slave      axis,
  output logic                          drop_pulse,
  output logic [31:0]                   drop_count
);

  localparam int BEAT_W = beat_width(ID_WIDTH);
  localparam int PL_W   = $bits(beat_payload_t);

  logic [BEAT_W-1:0]   in_beat;
  logic [BEAT_W-1:0]   head_beat;
  logic                head_valid;
  logic                head_pop;
  logic [ID_WIDTH-1:0] head_tid;
  beat_payload_t       head_pl;
  logic                tid_ok;

  demux_state_e        state_q;
  demux_state_e        state_d;
  logic [ID_WIDTH-1:0] lock_q;
  logic [ID_WIDTH-1:0] lock_d;
  logic [ID_WIDTH-1:0] sel_port;
  logic                sel_valid;
  logic                sel_ready;
  logic                drop_start;
  logic [31:0]         drop_count_q;
  logic [31:0]         drop_count_next;

  assign in_beat  = {axis.S_AXIS_tid, axis.S_AXIS_tdata, axis.S_AXIS_tdest, axis.S_AXIS_tlast};
  assign head_tid = head_beat[BEAT_W-1 -: ID_WIDTH];
  assign head_pl  = beat_payload_t'(head_beat[PL_W-1:0]);
  assign tid_ok   = (32'(head_tid) < 32'(NUM_PORTS));

  bsc_axis_skid_buffer #(
    .WIDTH (BEAT_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_beat),
    .in_valid  (axis.S_AXIS_tvalid),
    .in_ready  (axis.S_AXIS_tready),
    .out_data  (head_beat),
    .out_valid (head_valid),
    .out_pop   (head_pop)
  );

  // Selected port is the locked one mid-packet, otherwise the head beat's tid.
  always_comb begin
    sel_port  = (state_q == ST_PASS) ? lock_q : head_tid;
    sel_ready = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (sel_port == ID_WIDTH'(p)) begin
        sel_ready = axis.M_AXIS_tready[p];
      end
    end
  end

  // Packet routing FSM: decides when the head beat is consumed and where it goes.
  always_comb begin
    state_d    = state_q;
    lock_d     = lock_q;
    sel_valid  = 1'b0;
    head_pop   = 1'b0;
    drop_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (head_valid) begin
          if (tid_ok) begin
            sel_valid = 1'b1;
            if (sel_ready) begin
              head_pop = 1'b1;
              if (!head_pl.tlast) begin
                state_d = ST_PASS;
                lock_d  = head_tid;
              end
            end
          end else begin
            head_pop   = 1'b1;
            drop_start = 1'b1;
            if (!head_pl.tlast) begin
              state_d = ST_DROP;
            end
          end
        end
      end
      ST_PASS: begin
        sel_valid = head_valid;
        if (head_valid && sel_ready) begin
          head_pop = 1'b1;
          if (head_pl.tlast) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (head_valid) begin
          head_pop = 1'b1;
          if (head_pl.tlast) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Every port sees the head beat; only the selected one gets valid.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      axis.M_AXIS_tdata[DATA_W*p +: DATA_W] = head_pl.tdata;
      axis.M_AXIS_tdest[DEST_W*p +: DEST_W] = head_pl.tdest;
      axis.M_AXIS_tlast[p]                  = head_pl.tlast;
      axis.M_AXIS_tvalid[p]                 = sel_valid && (sel_port == ID_WIDTH'(p));
    end
  end

  // FSM state and the port locked for the open packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  // Saturating increment of the dropped-packet counter.
  always_comb begin
    drop_count_next = drop_count_q;
    if (drop_start && (drop_count_q != DROP_COUNT_MAX)) begin
      drop_count_next = drop_count_q + 32'd1;
    end
  end

  // Drop pulse and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_pulse   <= 1'b0;
      drop_count_q <= 32'd0;
    end else begin
      drop_pulse   <= drop_start;
      drop_count_q <= drop_count_next;
    end
  end

  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_bsc_axiu_axis_tid_demux.sv
// Directed bench for the tid demux: a 2-port instance and a 3-port instance
// (2-bit tid) share clock and reset.
module tb_bsc_axiu_axis_tid_demux;

  logic clk = 1'b0;
  logic rst;

  logic        drop_pulse2;
  logic [31:0] drop_count2;
  logic        drop_pulse3;
  logic [31:0] drop_count3;

  int n_compared   = 0;
  int n_mismatched = 0;

  bsc_axiu_axis_tid_demux_if #(.ID_WIDTH(1), .NUM_PORTS(2)) bus2 ();
  bsc_axiu_axis_tid_demux_if #(.ID_WIDTH(2), .NUM_PORTS(3)) bus3 ();

  bsc_axiu_axis_tid_demux #(.ID_WIDTH(1), .NUM_PORTS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .axis       (bus2),
    .drop_pulse (drop_pulse2),
    .drop_count (drop_count2)
  );

  bsc_axiu_axis_tid_demux #(.ID_WIDTH(2), .NUM_PORTS(3)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .axis       (bus3),
    .drop_pulse (drop_pulse3),
    .drop_count (drop_count3)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] d, input logic tid,
                               input logic [1:0] dest, input logic last);
    bus2.S_AXIS_tvalid = v;
    bus2.S_AXIS_tdata  = d;
    bus2.S_AXIS_tid    = tid;
    bus2.S_AXIS_tdest  = dest;
    bus2.S_AXIS_tlast  = last;
  endtask

  task automatic applyStimulus3(input logic v, input logic [63:0] d, input logic [1:0] tid,
                                input logic [1:0] dest, input logic last);
    bus3.S_AXIS_tvalid = v;
    bus3.S_AXIS_tdata  = d;
    bus3.S_AXIS_tid    = tid;
    bus3.S_AXIS_tdest  = dest;
    bus3.S_AXIS_tlast  = last;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 64'd0, 1'b0, 2'd0, 1'b0);
    applyStimulus3(1'b0, 64'd0, 2'd0, 2'd0, 1'b0);
    bus2.M_AXIS_tready = 2'b11;
    bus3.M_AXIS_tready = 3'b111;
    repeat (3) tick();

    // Reset state
    checkOutput("rst_s_tready", bus2.S_AXIS_tready, 1'b0);
    checkOutput("rst_m_tvalid", bus2.M_AXIS_tvalid, 2'b00);
    checkOutput("rst_drop_pulse", drop_pulse2, 1'b0);
    checkOutput("rst_drop_count", drop_count2, 32'd0);
    checkOutput("rst_m_tvalid3", bus3.M_AXIS_tvalid, 3'b000);

    rst = 1'b0;
    tick();
    checkOutput("ready_after_rst", bus2.S_AXIS_tready, 1'b1);
    checkOutput("ready_after_rst3", bus3.S_AXIS_tready, 1'b1);

    // Single-beat packets alternating tid 0/1, both ports ready: no bubbles
    for (int i = 0; i < 4; i++) begin
      int p;
      p = i % 2;
      applyStimulus(1'b1, 64'hA000 + 64'(i), p[0], 2'(i), 1'b1);
      tick();
      checkOutput($sformatf("alt%0d_valid", i), bus2.M_AXIS_tvalid, 64'(2'b01 << p));
      checkOutput($sformatf("alt%0d_data", i), bus2.M_AXIS_tdata[64*p +: 64], 64'hA000 + 64'(i));
      checkOutput($sformatf("alt%0d_dest", i), bus2.M_AXIS_tdest[2*p +: 2], 64'(i % 4));
      checkOutput($sformatf("alt%0d_last", i), bus2.M_AXIS_tlast[p], 1'b1);
      checkOutput($sformatf("alt%0d_sready", i), bus2.S_AXIS_tready, 1'b1);
    end
    applyStimulus(1'b0, 64'd0, 1'b0, 2'd0, 1'b0);
    tick();
    checkOutput("alt_idle_valid", bus2.M_AXIS_tvalid, 2'b00);
    checkOutput("alt_drop_count", drop_count2, 32'd0);

    // 4-beat packet on tid 1 with a bogus tid 0 on beat 2: lock holds
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 64'hB000 + 64'(i), (i == 1) ? 1'b0 : 1'b1, 2'd3, (i == 3));
      tick();
      checkOutput($sformatf("lock%0d_valid", i), bus2.M_AXIS_tvalid, 2'b10);
      checkOutput($sformatf("lock%0d_data", i), bus2.M_AXIS_tdata[127:64], 64'hB000 + 64'(i));
      checkOutput($sformatf("lock%0d_last", i), bus2.M_AXIS_tlast[1], (i == 3));
    end
    applyStimulus(1'b0, 64'd0, 1'b0, 2'd0, 1'b0);
    tick();
    checkOutput("lock_idle_valid", bus2.M_AXIS_tvalid, 2'b00);

    // Backpressure on port 0: buffer fills, ready drops, payload holds
    bus2.M_AXIS_tready = 2'b10;
    applyStimulus(1'b1, 64'hC000, 1'b0, 2'd1, 1'b0);
    tick();
    checkOutput("bp_first_valid", bus2.M_AXIS_tvalid, 2'b01);
    checkOutput("bp_first_sready", bus2.S_AXIS_tready, 1'b1);
    checkOutput("bp_first_data", bus2.M_AXIS_tdata[63:0], 64'hC000);
    applyStimulus(1'b1, 64'hC001, 1'b0, 2'd1, 1'b0);
    tick();
    checkOutput("bp_full_sready", bus2.S_AXIS_tready, 1'b0);
    checkOutput("bp_full_data", bus2.M_AXIS_tdata[63:0], 64'hC000);
    applyStimulus(1'b1, 64'hC002, 1'b0, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("bp_hold%0d_sready", i), bus2.S_AXIS_tready, 1'b0);
      checkOutput($sformatf("bp_hold%0d_valid", i), bus2.M_AXIS_tvalid, 2'b01);
      checkOutput($sformatf("bp_hold%0d_data", i), bus2.M_AXIS_tdata[63:0], 64'hC000);
    end
    bus2.M_AXIS_tready = 2'b11;
    tick();
    checkOutput("bp_rel1_data", bus2.M_AXIS_tdata[63:0], 64'hC001);
    checkOutput("bp_rel1_sready", bus2.S_AXIS_tready, 1'b1);
    tick();
    checkOutput("bp_rel2_data", bus2.M_AXIS_tdata[63:0], 64'hC002);
    checkOutput("bp_rel2_valid", bus2.M_AXIS_tvalid, 2'b01);
    applyStimulus(1'b1, 64'hC003, 1'b0, 2'd1, 1'b1);
    tick();
    checkOutput("bp_rel3_data", bus2.M_AXIS_tdata[63:0], 64'hC003);
    checkOutput("bp_rel3_last", bus2.M_AXIS_tlast[0], 1'b1);
    applyStimulus(1'b0, 64'd0, 1'b0, 2'd0, 1'b0);
    tick();
    checkOutput("bp_done_valid", bus2.M_AXIS_tvalid, 2'b00);

    // Reset in the middle of a tid-1 packet, then a tid-0 packet
    applyStimulus(1'b1, 64'hD000, 1'b1, 2'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 64'hD001, 1'b1, 2'd0, 1'b0);
    tick();
    checkOutput("mid_rst_pre_valid", bus2.M_AXIS_tvalid, 2'b10);
    checkOutput("mid_rst_pre_data", bus2.M_AXIS_tdata[127:64], 64'hD001);
    rst = 1'b1;
    applyStimulus(1'b0, 64'd0, 1'b0, 2'd0, 1'b0);
    tick();
    checkOutput("mid_rst_valid", bus2.M_AXIS_tvalid, 2'b00);
    checkOutput("mid_rst_sready", bus2.S_AXIS_tready, 1'b0);
    rst = 1'b0;
    tick();
    checkOutput("post_rst_sready", bus2.S_AXIS_tready, 1'b1);
    applyStimulus(1'b1, 64'hE000, 1'b0, 2'd2, 1'b1);
    tick();
    checkOutput("post_rst_valid", bus2.M_AXIS_tvalid, 2'b01);
    checkOutput("post_rst_data", bus2.M_AXIS_tdata[63:0], 64'hE000);
    applyStimulus(1'b0, 64'd0, 1'b0, 2'd0, 1'b0);
    tick();
    checkOutput("post_rst_idle", bus2.M_AXIS_tvalid, 2'b00);

    // Three-port instance: drop a 3-beat tid-3 packet, then route tid 2
    applyStimulus3(1'b1, 64'hF100, 2'd3, 2'd0, 1'b0);
    tick();
    checkOutput("drop_b0_valid", bus3.M_AXIS_tvalid, 3'b000);
    checkOutput("drop_b0_sready", bus3.S_AXIS_tready, 1'b1);
    checkOutput("drop_b0_pulse", drop_pulse3, 1'b0);
    applyStimulus3(1'b1, 64'hF101, 2'd0, 2'd0, 1'b0);
    tick();
    checkOutput("drop_b1_valid", bus3.M_AXIS_tvalid, 3'b000);
    checkOutput("drop_b1_pulse", drop_pulse3, 1'b1);
    checkOutput("drop_b1_count", drop_count3, 32'd1);
    checkOutput("drop_b1_sready", bus3.S_AXIS_tready, 1'b1);
    applyStimulus3(1'b1, 64'hF102, 2'd3, 2'd0, 1'b1);
    tick();
    checkOutput("drop_b2_valid", bus3.M_AXIS_tvalid, 3'b000);
    checkOutput("drop_b2_pulse", drop_pulse3, 1'b0);
    applyStimulus3(1'b1, 64'hF200, 2'd2, 2'd1, 1'b1);
    tick();
    checkOutput("after_drop_valid", bus3.M_AXIS_tvalid, 3'b100);
    checkOutput("after_drop_data", bus3.M_AXIS_tdata[191:128], 64'hF200);
    checkOutput("after_drop_dest", bus3.M_AXIS_tdest[5:4], 2'd1);
    applyStimulus3(1'b0, 64'd0, 2'd0, 2'd0, 1'b0);
    tick();
    checkOutput("after_drop_idle", bus3.M_AXIS_tvalid, 3'b000);
    checkOutput("after_drop_pulse", drop_pulse3, 1'b0);
    checkOutput("after_drop_count", drop_count3, 32'd1);

    // Saturation: preload near the top, then three single-beat invalid packets
    force dut3.drop_count_q = 32'hFFFF_FFFE;
    tick();
    release dut3.drop_count_q;
    #1;
    checkOutput("sat_preload", drop_count3, 32'hFFFF_FFFE);
    applyStimulus3(1'b1, 64'hF300, 2'd3, 2'd0, 1'b1);
    tick();
    checkOutput("sat_pre_pulse", drop_pulse3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin
        applyStimulus3(1'b1, 64'hF301 + 64'(i), 2'd3, 2'd0, 1'b1);
      end else begin
        applyStimulus3(1'b0, 64'd0, 2'd0, 2'd0, 1'b0);
      end
      tick();
      checkOutput($sformatf("sat%0d_pulse", i), drop_pulse3, 1'b1);
      checkOutput($sformatf("sat%0d_count", i), drop_count3, 32'hFFFF_FFFF);
      checkOutput($sformatf("sat%0d_valid", i), bus3.M_AXIS_tvalid, 3'b000);
    end
    tick();
    checkOutput("sat_end_pulse", drop_pulse3, 1'b0);
    checkOutput("sat_end_count", drop_count3, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/bsc_axiu_axis_tid_demux.md
# bsc_axiu_axis_tid_demux

Receive-side counterpart of the tid-tagging subset converter. Takes the merged 64-bit AXI-Stream from the interconnect, where each packet carries the tid of the accelerator it belongs to, and routes whole packets to one of NUM_PORTS per-accelerator master streams. Routing is locked per packet: tid is sampled only on the first beat and the lock is released only when the beat with tlast is accepted. Packets with an out-of-range tid are consumed, dropped and counted. A 2-entry input skid buffer gives full throughput with a registered S_AXIS_tready.

## Interface
- ID_WIDTH, 1: width of S_AXIS_tid.
- NUM_PORTS, 2: number of output streams, 1..2^ID_WIDTH; tid values >= NUM_PORTS are invalid.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- S_AXIS_tdata  in  64  input data.
- S_AXIS_tdest  in  2  passed through unchanged.
- S_AXIS_tid  in  ID_WIDTH  destination port; sampled on the first beat of a packet only.
- S_AXIS_tlast  in  1  end of packet.
- S_AXIS_tvalid  in  1  input valid.
- S_AXIS_tready  out  1  registered; high when the skid buffer has a free entry.
- M_AXIS_tdata  out  64*NUM_PORTS  port p uses bits [64p+63:64p].
- M_AXIS_tdest  out  2*NUM_PORTS  per-port tdest.
- M_AXIS_tlast  out  NUM_PORTS  per-port tlast.
- M_AXIS_tvalid  out  NUM_PORTS  per-port valid; at most one bit high at a time.
- M_AXIS_tready  in  NUM_PORTS  per-port ready.
- drop_pulse  out  1  one-cycle pulse when the first beat of an invalid-tid packet is consumed.
- drop_count  out  32  saturating count of dropped packets.

## Operation
- Skid buffer: 2-entry FIFO storing {tdata, tdest, tid, tlast}. Push on S_AXIS_tvalid && S_AXIS_tready. Pop when the head beat is consumed. S_AXIS_tready is registered and equals "fewer than 2 entries after this cycle's push/pop".
- The FSM uses three states.
  - IDLE: no packet open. The head beat's tid decides the route.
    - tid < NUM_PORTS: present the beat on port tid. When it is consumed, go to PASS with lock_port = tid, or stay in IDLE if the beat has tlast.
    - Otherwise: consume the beat immediately, pulse drop_pulse and increment drop_count. Go to DROP, or stay in IDLE if the beat has tlast.
  - PASS: the head beat goes to lock_port regardless of its tid. The beat with tlast, once consumed, returns the FSM to IDLE.
  - DROP: every head beat is consumed unconditionally without any M valid. The beat with tlast returns the FSM to IDLE.
- A beat is consumed when either of these holds:
  - M_AXIS_tvalid[p] && M_AXIS_tready[p] for the selected port p.
  - Any cycle in which the head beat is being dropped.
- Ports other than the selected one hold tvalid = 0. Their tdata, tdest and tlast are don't-care, and the implementation drives them with the head beat.
- drop_count saturates at 0xFFFFFFFF.

## Timing
- Reset values: S_AXIS_tready = 0, all M_AXIS_tvalid = 0, drop_pulse = 0, drop_count = 0, FSM in IDLE, FIFO empty.
- S_AXIS_tready rises on the first cycle after rst deasserts.
- Latency: a beat accepted at cycle n is presented on M at cycle n+1 when the FIFO was empty.
- Throughput is 1 beat/cycle sustained when the selected port's M_AXIS_tready is held high.
- Once M_AXIS_tvalid[p] is asserted, it and its payload stay stable until the beat is consumed (AXIS rule).
- A tid change in mid-packet is ignored; PASS keeps lock_port.
- Backpressure on one port stalls all traffic; there is no head-of-line bypass.
- Simultaneous push and pop with the FIFO full is allowed. S_AXIS_tready is already 0 in that state, so no push actually happens.
- rst asserted mid-packet flushes the FIFO and returns the FSM to IDLE. The downstream packet is truncated with no tlast. This is accepted behaviour; recovery is the host's responsibility.

## Structure
- Shared package holds the FSM state encoding (IDLE = 2'd0, PASS = 2'd1, DROP = 2'd2) and a beat struct/width constant: 64 + 2 + ID_WIDTH + 1.
- One sub-module: bsc_axis_skid_buffer, the 2-entry FIFO with registered ready, parameterised by payload width.
- The FSM, port selection and drop counter live in the top module.

## Test plan
- Single-beat packets alternating tid 0,1 with both M_AXIS_tready high -> each beat appears on the matching port one cycle after acceptance; no bubbles; drop_count = 0.
- 4-beat packet with tid = 1, where beat 2 carries tid = 0 -> all 4 beats on port 1; port 0 tvalid stays 0; tlast appears only on beat 4.
- NUM_PORTS = 3, ID_WIDTH = 2, 3-beat packet with tid = 3 -> S_AXIS_tready stays high, no M valid, drop_pulse is high for exactly one cycle, drop_count = 1; the next valid packet routes normally.
- Port 0 M_AXIS_tready low for 5 cycles during a packet -> S_AXIS_tready falls after 2 more beats are buffered; held M payload stays stable; no beat is lost or duplicated once ready returns.
- rst asserted on beat 2 of a 4-beat packet -> next cycle all M_AXIS_tvalid = 0 and S_AXIS_tready = 0; after release, a new tid = 0 packet routes to port 0.
- drop_count preloaded via force to 0xFFFFFFFE, then 3 invalid packets sent -> drop_count = 0xFFFFFFFF, and drop_pulse still fires for each packet.
